add_seq_ctrl: RTL and testbench

Nibble-serial add/subtract sequencer that drives a single `add4` 4-bit ripple adder slice over multiple cycles to produce a 4·NIBBLES-bit result. It latches operands on a start request and feeds one nibble per cycle through the slice, least-significant first. The carry is registered between cycles. On completion it publishes sum, carry-out and signed overflow with a one-cycle done pulse. It sits between a requesting datapath (sequencer/ALU control) and the shared adder slice, trading latency for area.

---
 rtl/add_seq_ctrl_if.sv | 28 ++
 rtl/add_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_add_seq_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/add_seq_ctrl_if.sv
// Request/result bundle between a requesting datapath and add_seq_ctrl.
// master drives the operation, slave is the nibble-serial sequencer.
interface add_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic         cy_in;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, cy_in, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cy_in, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// Nibble-serial add/subtract sequencer driving one shared 4-bit ripple slice.
// Operands are latched on start and processed LSB nibble first.
module add4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cy_in,
    output logic [3:0] s,
    output logic       cy4
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cy_in;
        for (int i = 0; i < 4; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cy4 = c[4];
endmodule

module add_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic           clk,
    input logic           rst,
    add_seq_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  work_reg;
    logic [W-1:0]  work_next;
    logic [3:0]    x_nib;
    logic [3:0]    y_nib;
    logic [3:0]    s;
    logic          cy4;

    assign x_nib = a_reg[idx*4 +: 4];
    assign y_nib = b_reg[idx*4 +: 4];

    add4 u_add4 (
        .x     (x_nib),
        .y     (y_nib),
        .cy_in (carry_reg),
        .s     (s),
        .cy4   (cy4)
    );

    // Work word with the current slice output merged in, so the final
    // nibble can be published in the same edge that leaves RUN.
    always_comb begin
        work_next             = work_reg;
        work_next[idx*4 +: 4] = s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            work_reg  <= '0;
            bus.sum   <= '0;
            bus.cout  <= 1'b0;
            bus.ovf   <= 1'b0;
            bus.done  <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.sub ? ~bus.b : bus.b;
                        carry_reg <= bus.cy_in ^ bus.sub;
                        idx       <= '0;
                        bus.busy  <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    work_reg  <= work_next;
                    carry_reg <= cy4;
                    if (idx == LAST) begin
                        bus.sum  <= work_next;
                        bus.cout <= cy4;
                        bus.ovf  <= (a_reg[W-1] == b_reg[W-1]) &&
                                    (work_next[W-1] != a_reg[W-1]);
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl: scoreboard of expected results popped
// on each done pulse, plus cycle-exact busy/done/reset/hold checks.
module tb_add_seq_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    add_seq_ctrl_if #(.NIBBLES(N)) bus ();

    add_seq_ctrl #(.NIBBLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_t sb[$];
    res_t mon_e;
    res_t mon_o;
    res_t last;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cy);
        logic [W:0] r;
        res_t       e;
        if (!sub) begin
            r     = {1'b0, a} + {1'b0, b} + (W+1)'(cy);
            e.ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r     = {1'b0, a} + {1'b0, ~b} + (W+1)'(!cy);
            e.ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
        e.sum  = r[W-1:0];
        e.cout = r[W];
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus.done) begin
            n_done++;
            mon_o = {bus.sum, bus.cout, bus.ovf};
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_done: observed %0h expected none", mon_o);
            end else begin
                mon_e = sb.pop_front();
                chk("result", 32'(mon_o), 32'(mon_e));
                last = mon_e;
            end
        end
    end

    // Operands are scrambled after acceptance; the result must not change.
    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic sub,
                          input logic cy, input res_t e);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.cy_in = cy;
        bus.start = 1'b1;
        sb.push_back(e);
        tick();
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.sub   = ~sub;
        for (int k = 1; k <= N; k++) begin
            chk({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
            chk({tag, "_done_low"}, 32'(bus.done), 32'd0);
            tick();
        end
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(e.sum));
        tick();
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int   d0;
        res_t e;
        logic [W-1:0] ra, rb;
        logic rs, rc;

        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cy_in = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;
        tick();

        run_op("add", 16'h1234, 16'h0FFF, 1'b0, 1'b0, '{16'h2233, 1'b0, 1'b0});
        run_op("chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0});
        run_op("addovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1});
        run_op("sub", 16'h0005, 16'h0007, 1'b1, 1'b0, '{16'hFFFE, 1'b0, 1'b0});
        run_op("subovf", 16'h8000, 16'h0001, 1'b1, 1'b0, '{16'h7FFF, 1'b1, 1'b1});
        run_op("borrow", 16'h0010, 16'h0001, 1'b1, 1'b1, '{16'h000E, 1'b1, 1'b0});

        // start pulses in cycles 2 and 5 must be ignored
        d0        = n_done;
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
        bus.sub   = 1'b0;
        bus.cy_in = 1'b0;
        bus.start = 1'b1;
        sb.push_back('{16'h0002, 1'b0, 1'b0});
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("rej_done_c5", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        tick();
        chk("rej_busy_c6", 32'(bus.busy), 32'd0);
        chk("rej_one_done", 32'(n_done - d0), 32'd1);
        bus.b = 16'h1111;
        sb.push_back('{16'hBBBB, 1'b0, 1'b0});
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        chk("rej_done_c10", 32'(bus.done), 32'd0);
        tick();
        chk("rej_done_c11", 32'(bus.done), 32'd1);
        chk("rej_busy_c11", 32'(bus.busy), 32'd1);
        tick();
        chk("rej_busy_c12", 32'(bus.busy), 32'd0);

        // reset in cycle 3 of an operation discards it
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_sum", 32'(bus.sum), 32'd0);
        chk("mid_rst_cout", 32'(bus.cout), 32'd0);
        chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        d0 = n_done;
        repeat (8) tick();
        chk("mid_rst_no_done", 32'(n_done - d0), 32'd0);
        run_op("after_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, '{16'h0007, 1'b0, 1'b0});

        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            e  = model(ra, rb, rs, rc);
            run_op("rand", ra, rb, rs, rc, e);
        end

        run_op("pre_hold", 16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1});
        for (int i = 0; i < 20; i++) begin
            bus.start = 1'b0;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.sub   = 1'($urandom_range(0, 1));
            tick();
            chk("hold_sum", 32'(bus.sum), 32'h8000);
            chk("hold_cout", 32'(bus.cout), 32'd0);
            chk("hold_ovf", 32'(bus.ovf), 32'd1);
            chk("hold_done", 32'(bus.done), 32'd0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
